// File: rtl/frame_fill_sequencer.sv
// rtl/frame_fill_sequencer.sv - write-side frame buffer sequencer: block sweep, trace requests, vblank-gated bank swap
module frame_fill_sequencer #(
  parameter int COLS   = 128,
  parameter int ROWS   = 64,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 6,
  parameter int DATA_W = 12
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   enable,
  input  logic                   vblank,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [COL_W-1:0]       req_col,
  output logic [ROW_W-1:0]       req_row,
  input  logic                   resp_valid,
  input  logic [DATA_W-1:0]      resp_data,
  output logic                   wr_en,
  output logic [COL_W+ROW_W-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   wr_bank,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_SWAP_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   req_valid_q, req_valid_d;
  logic                   wr_en_q, wr_en_d;
  logic [COL_W+ROW_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   frame_done_q, frame_done_d;
  logic [7:0]             frame_cnt_q, frame_cnt_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  // vblank crosses from the VGA domain: two sync stages plus a history flop for edge detect
  logic vb_meta_q, vb_meta_d;
  logic vb_sync_q, vb_sync_d;
  logic vb_prev_q, vb_prev_d;
  logic vb_rise;
  logic last_col;
  logic last_blk;

  assign vb_rise  = vb_sync_q & ~vb_prev_q;
  assign last_col = (col_q == COL_W'(COLS - 1));
  assign last_blk = last_col && (row_q == ROW_W'(ROWS - 1));

  // next-state and registered-output computation for the sweep FSM
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    req_valid_d  = req_valid_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_bank_d    = wr_bank_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    vb_meta_d    = vblank;
    vb_sync_d    = vb_meta_q;
    vb_prev_d    = vb_sync_q;
    // a response is only legal while a request is outstanding; anything else is dropped and flagged
    err_d        = err_q | (resp_valid && (state_q != S_WAIT));

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_ISSUE;
          col_d       = '0;
          row_d       = '0;
          req_valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = {row_q, col_q};
          wr_data_d = resp_data;
        end
      end
      S_WRITE: begin
        if (last_col) begin
          col_d = '0;
          row_d = last_blk ? '0 : row_q + ROW_W'(1);
        end else begin
          col_d = col_q + COL_W'(1);
        end
        if (last_blk) begin
          state_d = S_SWAP_WAIT;
        end else begin
          state_d     = S_ISSUE;
          req_valid_d = 1'b1;
        end
      end
      S_SWAP_WAIT: begin
        // swapping only here keeps the bank fixed for every write of the frame
        if (vb_rise) begin
          wr_bank_d    = ~wr_bank_q;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          if (enable) begin
            state_d     = S_ISSUE;
            req_valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // state, counters, synchronizer and registered outputs; reset abandons any partial frame
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      req_valid_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_bank_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      vb_meta_q    <= 1'b0;
      vb_sync_q    <= 1'b0;
      vb_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      req_valid_q  <= req_valid_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_bank_q    <= wr_bank_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      vb_meta_q    <= vb_meta_d;
      vb_sync_q    <= vb_sync_d;
      vb_prev_q    <= vb_prev_d;
    end
  end

  assign req_valid  = req_valid_q;
  assign req_col    = col_q;
  assign req_row    = row_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_bank    = wr_bank_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_frame_fill_sequencer.sv
// tb/tb_frame_fill_sequencer.sv - self-checking bench for frame_fill_sequencer
module tb_frame_fill_sequencer;
  localparam int COLS = 128;
  localparam int ROWS = 64;
  localparam int NBLK = COLS * ROWS;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        enable = 1'b0;
  logic        vblank = 1'b0;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [11:0] resp_data = 12'h000;
  logic        req_valid;
  logic [6:0]  req_col;
  logic [5:0]  req_row;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_bank;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;
  int wr_count = 0;
  int fd_count = 0;

  always #5 clk = ~clk;

  frame_fill_sequencer dut (
    .clk(clk), .clrn(clrn), .enable(enable), .vblank(vblank),
    .req_valid(req_valid), .req_ready(req_ready), .req_col(req_col), .req_row(req_row),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy), .err(err)
  );

  // independent tallies of write strobes and swap pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en) wr_count++;
    if (frame_done) fd_count++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rnd_wait();
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(1, 3));
    return 0;
  endfunction

  // one tracer transaction for raster block index k; the reference is k itself
  task automatic do_block(input int k, input int rdy_wait, input int rsp_wait,
                          input logic [11:0] data, input bit spurious);
    int n;
    logic [5:0] er;
    logic [6:0] ec;
    er = 6'(k / COLS);
    ec = 7'(k % COLS);
    n = 0;
    while (!req_valid && n < 50) begin
      tick();
      n++;
    end
    check("req", {req_valid, req_row, req_col}, {1'b1, er, ec});
    for (int i = 0; i < rdy_wait; i++) begin
      if (spurious && i == 0) begin
        resp_valid = 1'b1;
        resp_data  = 12'hFFF;
      end
      tick();
      resp_valid = 1'b0;
      check("req_hold", {req_valid, req_row, req_col, wr_en}, {1'b1, er, ec, 1'b0});
    end
    if (spurious) check("err_set", err, 1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("req_drop", req_valid, 0);
    repeat (rsp_wait) tick();
    resp_valid = 1'b1;
    resp_data  = data;
    tick();
    resp_valid = 1'b0;
    check("write", {wr_en, wr_addr, wr_data}, {1'b1, 13'(k), data});
    tick();
    check("wr_pulse", wr_en, 0);
  endtask

  task automatic wait_swap(output int n);
    n = 0;
    while (!frame_done && n < 10) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int base;

    // reset held with enable high and vblank toggling
    clrn   = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vblank = ~vblank;
      tick();
      check("reset_outs", {req_valid, req_col, req_row, wr_en, wr_addr, wr_data, wr_bank,
                           frame_done, frame_cnt, busy, err}, 64'd0);
    end
    vblank = 1'b0;
    clrn = 1'b1;
    tick();
    check("release_req", {req_valid, req_row, req_col, busy}, {1'b1, 6'd0, 7'd0, 1'b1});

    // directed handshake: ready late by 5 cycles, response 3 cycles after acceptance
    do_block(0, 5, 2, 12'hABC, 1'b0);
    check("next_col", {req_valid, req_row, req_col}, {1'b1, 6'd0, 7'd1});

    // rest of frame 1 with random data and delays, a stray vblank and one spurious response
    for (int k = 1; k < NBLK; k++) begin
      if (k == 1000) vblank = 1'b1;
      if (k == 1004) vblank = 1'b0;
      do_block(k, (k == 50) ? 2 : rnd_wait(), rnd_wait(), 12'($urandom), k == 50);
    end
    check("f1_writes", wr_count, NBLK);
    check("f1_no_swap", {fd_count[7:0], wr_bank, frame_cnt, busy, req_valid}, {8'd0, 1'b0, 8'd0, 1'b1, 1'b0});
    repeat (10) tick();
    check("f1_hold", {fd_count[7:0], wr_bank, busy}, {8'd0, 1'b0, 1'b1});

    // swap on vblank, then the next frame starts at (0,0)
    vblank = 1'b1;
    wait_swap(n);
    check("swap_latency", (n >= 2 && n <= 3), 1);
    check("swap_state", {frame_done, wr_bank, frame_cnt, req_valid, req_row, req_col, err},
          {1'b1, 1'b1, 8'd1, 1'b1, 6'd0, 7'd0, 1'b1});
    tick();
    check("swap_pulse", {frame_done, fd_count[7:0]}, {1'b0, 8'd1});
    vblank = 1'b0;

    // partial frame, then reset while block (3,17) is being requested
    for (int k = 0; k < 3 * COLS + 17; k++) do_block(k, rnd_wait(), rnd_wait(), 12'($urandom), 1'b0);
    check("mid_req", {req_valid, req_row, req_col}, {1'b1, 6'd3, 7'd17});
    clrn = 1'b0;
    tick();
    tick();
    check("mid_reset", {wr_bank, frame_cnt, err, busy, req_valid, wr_en, frame_done}, 64'd0);
    clrn = 1'b1;
    tick();
    check("restart_req", {req_valid, req_row, req_col}, {1'b1, 6'd0, 7'd0});

    // frame 2 from scratch; enable drops mid-frame, which must not stop rendering
    base = wr_count;
    for (int k = 0; k < NBLK; k++) begin
      if (k == NBLK / 2) enable = 1'b0;
      do_block(k, rnd_wait(), rnd_wait(), 12'($urandom), 1'b0);
    end
    check("f2_writes", wr_count - base, NBLK);
    check("f2_wait", {busy, req_valid, wr_bank, frame_cnt}, {1'b1, 1'b0, 1'b0, 8'd0});
    vblank = 1'b1;
    wait_swap(n);
    check("swap2_latency", (n >= 2 && n <= 3), 1);
    check("swap2_state", {frame_done, wr_bank, frame_cnt, err, req_valid}, {1'b1, 1'b1, 8'd1, 1'b0, 1'b0});
    tick();
    check("idle_after", {busy, req_valid, frame_done}, {1'b0, 1'b0, 1'b0});
    vblank = 1'b0;
    repeat (5) tick();
    check("stay_idle", {busy, req_valid, wr_en}, {1'b0, 1'b0, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
